// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// FIFO controller wrapped around an external dual-port RAM with an
// asynchronous read port. The RAM holds the bulk storage; this block owns
// the write/read pointers, RAM occupancy, flow control and a registered
// output stage that is prefetched from the RAM's combinational read data.
//
// Ports:
//   clk          single clock, all state on the rising edge
//   rst          synchronous, active-high reset
//   wr_valid     write request from the producer
//   wr_ready     a write can be accepted this cycle
//   wr_data      write data word
//   rd_valid     rd_data holds a valid word
//   rd_ready     consumer takes rd_data this cycle
//   rd_data      registered output word
//   count        words held in RAM plus the output register (0..DEPTH+1)
//   almost_full  count >= AF_LEVEL
//   ram_we       RAM write enable (active-high)
//   ram_addr_wr  RAM write address
//   ram_data_wr  RAM write data
//   ram_addr_rd  RAM read address
//   ram_data_rd  RAM asynchronous read data for ram_addr_rd
module ram_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 2),
  parameter int AF_LEVEL  = DEPTH - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic [CNT_W-1:0]     count,
  output logic                 almost_full,
  output logic                 ram_we,
  output logic [DEPTH_LOG-1:0] ram_addr_wr,
  output logic [WIDTH-1:0]     ram_data_wr,
  output logic [DEPTH_LOG-1:0] ram_addr_rd,
  input  logic [WIDTH-1:0]     ram_data_rd
);

  localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     AF_CNT    = CNT_W'(AF_LEVEL);

  logic [DEPTH_LOG-1:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]     ramCnt_q, ramCnt_d;
  logic                 rdValid_q, rdValid_d;
  logic [WIDTH-1:0]     rdData_q, rdData_d;
  logic                 accept;
  logic                 load;

  // DEPTH need not be a power of two, so the wrap is an explicit compare
  // rather than relying on natural pointer overflow.
  function automatic logic [DEPTH_LOG-1:0] nextPtr(input logic [DEPTH_LOG-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + DEPTH_LOG'(1);
  endfunction

  // Handshake decode. A load refills the output register whenever it is
  // empty or being consumed; a full RAM blocks writes even if a load frees
  // a slot in the same cycle (no pass-through).
  always_comb begin
    wr_ready = !rst && (ramCnt_q != FULL_CNT);
    accept   = wr_valid && wr_ready;
    load     = (ramCnt_q != '0) && (!rdValid_q || rd_ready);
  end

  // Next-state for pointers, occupancy and the output stage.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    ramCnt_d  = ramCnt_q;
    rdValid_d = rdValid_q;
    rdData_d  = rdData_q;

    if (accept) begin
      wrPtr_d = nextPtr(wrPtr_q);
    end

    if (load) begin
      rdData_d  = ram_data_rd;
      rdValid_d = 1'b1;
      rdPtr_d   = nextPtr(rdPtr_q);
    end else if (rdValid_q && rd_ready) begin
      // Consumer took the last word and the RAM is empty; rd_data keeps
      // its stale value.
      rdValid_d = 1'b0;
    end

    case ({accept, load})
      2'b10:   ramCnt_d = ramCnt_q + CNT_W'(1);
      2'b01:   ramCnt_d = ramCnt_q - CNT_W'(1);
      default: ramCnt_d = ramCnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      ramCnt_q  <= '0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      ramCnt_q  <= ramCnt_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
    end
  end

  assign ram_we      = accept;
  assign ram_addr_wr = wrPtr_q;
  assign ram_data_wr = wr_data;
  assign ram_addr_rd = rdPtr_q;
  assign rd_valid    = rdValid_q;
  assign rd_data     = rdData_q;
  assign count       = ramCnt_q + CNT_W'(rdValid_q);
  assign almost_full = (count >= AF_CNT);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// Bench for ram_fifo_ctrl with DEPTH=16, WIDTH=8. Provides the external
// asynchronous-read RAM behaviourally, keeps a queue-based model of the
// FIFO contents (RAM words as a queue plus one output slot, addresses as
// running totals modulo DEPTH) and compares every DUT output against it on
// each falling edge. Directed sequences add literal expectations.
module tb_ram_fifo_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;

  logic             clk;
  logic             rst;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [4:0]       count;
  logic             almost_full;
  logic             ram_we;
  logic [3:0]       ram_addr_wr;
  logic [WIDTH-1:0] ram_data_wr;
  logic [3:0]       ram_addr_rd;
  logic [WIDTH-1:0] ram_data_rd;

  int checks   = 0;
  int failures = 0;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .almost_full (almost_full),
    .ram_we      (ram_we),
    .ram_addr_wr (ram_addr_wr),
    .ram_data_wr (ram_data_wr),
    .ram_addr_rd (ram_addr_rd),
    .ram_data_rd (ram_data_rd)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: synchronous write, asynchronous read.
  logic [WIDTH-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_wr] <= ram_data_wr;
  end
  assign ram_data_rd = mem[ram_addr_rd];

  // Reference model state.
  logic [WIDTH-1:0] mq [$];
  logic             mOutValid;
  logic [WIDTH-1:0] mOutData;
  int               wrTotal;
  int               rdTotal;
  bit               modelReady = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance on each rising edge using the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mOutValid  = 1'b0;
      mOutData   = '0;
      wrTotal    = 0;
      rdTotal    = 0;
      modelReady = 1;
    end else if (modelReady) begin
      bit doAcc;
      bit doLoad;
      doAcc  = wr_valid && (mq.size() != DEPTH);
      doLoad = (mq.size() != 0) && (!mOutValid || rd_ready);
      if (doLoad) begin
        mOutData  = mq.pop_front();
        mOutValid = 1'b1;
        rdTotal++;
      end else if (mOutValid && rd_ready) begin
        mOutValid = 1'b0;
      end
      if (doAcc) begin
        mq.push_back(wr_data);
        wrTotal++;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (modelReady) begin
      bit expReady;
      bit expWe;
      int expCnt;
      expReady = !rst && (mq.size() != DEPTH);
      expWe    = wr_valid && expReady;
      expCnt   = mq.size() + (mOutValid ? 1 : 0);
      checkOutput("wr_ready", int'(wr_ready), int'(expReady));
      checkOutput("ram_we", int'(ram_we), int'(expWe));
      checkOutput("rd_valid", int'(rd_valid), int'(mOutValid));
      checkOutput("rd_data", int'(rd_data), int'(mOutData));
      checkOutput("count", int'(count), expCnt);
      checkOutput("almost_full", int'(almost_full), (expCnt >= AF) ? 1 : 0);
      checkOutput("ram_addr_wr", int'(ram_addr_wr), wrTotal % DEPTH);
      checkOutput("ram_addr_rd", int'(ram_addr_rd), rdTotal % DEPTH);
      if (expWe) checkOutput("ram_data_wr", int'(ram_data_wr), int'(wr_data));
    end
  end

  logic [WIDTH-1:0] popped [$];
  int maxCnt;

  // One clock of stimulus; records the word the consumer takes at this edge.
  task automatic applyStimulus(input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
    if (rd_valid && rr) popped.push_back(rd_data);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(posedge clk);
    #1;
    if (int'(count) > maxCnt) maxCnt = int'(count);
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset then idle.
    checkOutput("t1_rd_valid", int'(rd_valid), 0);
    checkOutput("t1_count", int'(count), 0);
    checkOutput("t1_wr_ready", int'(wr_ready), 1);
    checkOutput("t1_ram_we", int'(ram_we), 0);
    checkOutput("t1_rd_data", int'(rd_data), 0);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Three writes, observe two-edge latency.
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("t2_rd_valid_e1", int'(rd_valid), 0);
    checkOutput("t2_addr_wr_e1", int'(ram_addr_wr), 1);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("t2_rd_valid_e2", int'(rd_valid), 1);
    checkOutput("t2_rd_data_e2", int'(rd_data), 8'h11);
    applyStimulus(1'b1, 8'h33, 1'b0);
    checkOutput("t2_count", int'(count), 3);
    checkOutput("t2_addr_wr_e3", int'(ram_addr_wr), 3);
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Fresh start, fill to 17, then drain in order.
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput("t3_fill_af", int'(almost_full), (i + 1 >= 14) ? 1 : 0);
    end
    checkOutput("t3_full_count", int'(count), 17);
    checkOutput("t3_full_wr_ready", int'(wr_ready), 0);
    for (int i = 0; i < 17; i++) begin
      checkOutput("t3_drain_valid", int'(rd_valid), 1);
      checkOutput("t3_drain_data", int'(rd_data), i);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("t3_empty_valid", int'(rd_valid), 0);
    checkOutput("t3_empty_count", int'(count), 0);

    // Streaming 40 words through, pointers wrap twice.
    popped.delete();
    maxCnt = 0;
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t4_popped_n", popped.size(), 40);
    for (int i = 0; i < popped.size() && i < 40; i++)
      checkOutput("t4_order", int'(popped[i]), (8'h80 + i) & 8'hFF);
    checkOutput("t4_max_count", (maxCnt <= 2) ? 1 : 0, 1);

    // Full RAM with a pop in the same cycle: write waits one cycle.
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    checkOutput("t5_count17", int'(count), 17);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    rd_ready = 1'b1;
    #1;
    checkOutput("t5_no_we", int'(ram_we), 0);
    checkOutput("t5_no_ready", int'(wr_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("t5_count16", int'(count), 16);
    checkOutput("t5_rd_data", int'(rd_data), 1);
    rd_ready = 1'b0;
    #1;
    checkOutput("t5_we", int'(ram_we), 1);
    @(posedge clk);
    #1;
    checkOutput("t5_count17b", int'(count), 17);

    // Reset mid-operation at count 9, then a single write.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t6_count9", int'(count), 9);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("t6_count0", int'(count), 0);
    checkOutput("t6_rd_valid0", int'(rd_valid), 0);
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("t6_not_yet", int'(rd_valid), 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_rd_valid", int'(rd_valid), 1);
    checkOutput("t6_rd_data", int'(rd_data), 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream and downstream of the dual-port RAM with asynchronous read (ram_dp_async_read).
- Accepts a valid/ready write stream and drives the RAM write port.
- Drives the RAM read address and consumes the async read data into a registered output stage.
- Presents a valid/ready read stream.
- RAM storage is external; this block owns pointers, occupancy, flow control and the output register.

Parameters:
WIDTH, 8, data word width; must match the RAM WIDTH
DEPTH, 16, RAM entries; must match the RAM DEPTH; >=2; need not be a power of two
DEPTH_LOG, $clog2(DEPTH), RAM address width
CNT_W, $clog2(DEPTH+2), width of count
AF_LEVEL, DEPTH-2, almost_full threshold on count

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
wr_valid  in  1  write request
wr_ready  out  1  block can accept a write this cycle
wr_data  in  WIDTH  write data
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer takes rd_data this cycle
rd_data  out  WIDTH  registered output word
count  out  CNT_W  total words held (RAM + output register), 0..DEPTH+1
almost_full  out  1  count >= AF_LEVEL
ram_we  out  1  RAM write enable, active-high (RAM writes when this is 1, despite its port name we_n)
ram_addr_wr  out  DEPTH_LOG  RAM write address
ram_data_wr  out  WIDTH  RAM write data
ram_addr_rd  out  DEPTH_LOG  RAM read address
ram_data_rd  in  WIDTH  RAM async read data, ram[ram_addr_rd], same cycle

Behaviour:
- State registers: wr_ptr, rd_ptr (DEPTH_LOG bits), ram_cnt (0..DEPTH), rd_valid, rd_data.
- Reset (rst=1 at clk edge): wr_ptr=0, rd_ptr=0, ram_cnt=0, rd_valid=0, rd_data=0.
  - While rst=1, wr_ready=0 and ram_we=0.
  - Mid-operation reset discards all contents; RAM contents are not cleared but become unreachable.
- Outputs after reset: count=0, almost_full=0 (for AF_LEVEL>0), ram_addr_wr=0, ram_addr_rd=0.
- Write side:
  - wr_ready = !rst && ram_cnt != DEPTH.
  - accept = wr_valid && wr_ready.
  - ram_we = accept (combinational), ram_addr_wr = wr_ptr, ram_data_wr = wr_data.
  - On accept, wr_ptr advances; it wraps from DEPTH-1 to 0.
  - wr_valid while full: no write, no state change; the producer must hold its data.
- Read side (prefetch):
  - ram_addr_rd = rd_ptr at all times.
  - load = ram_cnt != 0 && (!rd_valid || rd_ready).
  - On load: rd_data <= ram_data_rd, rd_valid <= 1, and rd_ptr advances with the same wrap rule.
  - When rd_valid && rd_ready && ram_cnt == 0: rd_valid <= 0, and rd_data holds its old value.
  - Otherwise rd_data and rd_valid hold.
- Occupancy:
  - ram_cnt_next = ram_cnt + accept - load.
  - count = ram_cnt + rd_valid (combinational from registers).
  - almost_full = count >= AF_LEVEL.
- Latency:
  - A write into an empty FIFO appears as rd_valid=1 two edges after the accepting edge: edge 1 writes the RAM, edge 2 loads the output register.
  - There is no write-to-read bypass.
  - Sustained throughput is 1 word/cycle once rd_valid=1 and rd_ready=1.
- Simultaneous events:
  - Accept and load in the same cycle: ram_cnt is unchanged and both pointers advance.
  - With ram_cnt == DEPTH and a load in the same cycle, wr_ready is still 0. The slot frees on the next cycle; there is no same-cycle pass-through.
  - Read and write pointers never address the same entry with both a valid write and a load in one cycle unless ram_cnt == DEPTH, which blocks the write.
- Ordering: strict FIFO order; no data loss or duplication under any valid/ready pattern.

Test Plan:
1. Reset then idle -> rd_valid=0, count=0, wr_ready=1, ram_we=0, rd_data=0.
2. Write 0x11,0x22,0x33 on consecutive cycles with rd_ready=0 -> rd_valid rises 2 edges after the first accept with rd_data=0x11; count reaches 3; ram_addr_wr steps 0,1,2.
3. Fill with rd_ready=0 -> 17 words accepted (16 in RAM + 1 in output register); wr_ready=0 at count=17; almost_full=1 from count=14. Then drain with rd_ready=1 -> 0x00..0x10 out in order, one per cycle.
4. Pointer wrap: continuous push and pop for 40 words with rd_ready=1 -> both pointers wrap 15->0 twice; output sequence matches input; count stays at or below 2.
5. RAM full with a pop in the same cycle (ram_cnt=16, rd_valid=1, rd_ready=1, wr_valid=1) -> no accept that cycle; accept occurs the next cycle; count 17->16->17.
6. Assert rst for one cycle with count=9 -> next cycle count=0, rd_valid=0; a subsequent write of 0xA5 appears as rd_data=0xA5 two edges later.
